// File: rtl/avg_engine.sv
// Block averaging engine: accepts 2^LOG_N unsigned samples over valid/ready,
// accumulates at full precision, then reports the sum and the truncated or rounded average.
module avg_engine #(
  parameter int WIDTH = 8,
  parameter int LOG_N = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   round,
  input  logic                   in_valid,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   in_ready,
  output logic                   ready,
  output logic                   busy,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       out_avg,
  output logic [WIDTH+LOG_N-1:0] out_sum
);

  // state | meaning
  // IDLE  | waiting for start
  // ARM   | acc/cnt cleared, round latched; waits for start release
  // ACC   | accepting samples
  // CALC  | registering sum and average
  // DONE  | one-cycle out_valid
  localparam int SW = WIDTH + LOG_N;
  localparam int N  = 1 << LOG_N;
  localparam logic [SW-1:0]    HALF     = SW'(N / 2);
  localparam logic [LOG_N-1:0] CNT_LAST = LOG_N'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_ACC,
    S_CALC,
    S_DONE
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [SW-1:0]     acc;
  logic [SW-1:0]     sum_rnd;
  logic [LOG_N-1:0]  cnt;
  logic              rnd_q;
  logic              take;

  always_comb begin
    state_next = state;
    take       = 1'b0;
    case (state)
      S_IDLE: if (start) state_next = S_ARM;
      S_ARM:  if (!start) state_next = S_ACC;
      S_ACC: begin
        // a restart wins over a sample presented in the same cycle
        if (start) begin
          state_next = S_ARM;
        end else if (in_valid) begin
          take = 1'b1;
          if (cnt == CNT_LAST) state_next = S_CALC;
        end
      end
      S_CALC: state_next = S_DONE;
      S_DONE: state_next = start ? S_ARM : S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Width SW holds N*(2^WIDTH-1) + N/2 without overflow.
  assign sum_rnd = acc + (rnd_q ? HALF : '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      cnt     <= '0;
      rnd_q   <= 1'b0;
      out_sum <= '0;
      out_avg <= '0;
    end else begin
      // clearing on entry as well makes acc/cnt read zero throughout ARM
      if (state_next == S_ARM) begin
        acc <= '0;
        cnt <= '0;
      end else if (take) begin
        acc <= acc + SW'(in_data);
        cnt <= cnt + LOG_N'(1);
      end
      if (state == S_ARM) rnd_q <= round;
      if (state == S_CALC) begin
        out_sum <= acc;
        out_avg <= WIDTH'(sum_rnd >> LOG_N);
      end
    end
  end

  assign ready     = (state == S_IDLE);
  assign busy      = (state == S_ARM) || (state == S_ACC) || (state == S_CALC);
  assign in_ready  = (state == S_ACC);
  assign out_valid = (state == S_DONE);

endmodule

// File: tb/tb_avg_engine.sv
// Directed bench for avg_engine (WIDTH=8, LOG_N=2) with hand-computed expectations.
module tb_avg_engine;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       round = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_ready, ready, busy, out_valid;
  logic [7:0] out_avg;
  logic [9:0] out_sum;

  int tests_run = 0;
  int failures  = 0;

  avg_engine #(.WIDTH(8), .LOG_N(2)) dut (
    .clk(clk), .rst(rst), .start(start), .round(round),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .ready(ready), .busy(busy), .out_valid(out_valid),
    .out_avg(out_avg), .out_sum(out_sum)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the engine in ACC: edge 1 IDLE->ARM, edge 2 ARM->ACC.
  task automatic start_run(input logic r);
    round = r;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
  endtask

  task automatic feed(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    tests_run++;
    if ({ready, busy, in_ready, out_valid} !== 4'b1000) begin
      failures++;
      $display("FAIL reset_flags: got %b expected 1000", {ready, busy, in_ready, out_valid});
    end
    @(negedge clk);
    rst = 1'b0;
    start_run(1'b0);
    feed(8'd5);
    #2;
    rst = 1'b1;
    #1;
    tests_run++;
    if ({ready, busy, in_ready, out_valid} !== 4'b1000) begin
      failures++;
      $display("FAIL reset_mid_flags: got %b expected 1000", {ready, busy, in_ready, out_valid});
    end
    tests_run++;
    if (out_avg !== 8'd0 || out_sum !== 10'd0) begin
      failures++;
      $display("FAIL reset_outs: got avg %0d sum %0d expected 0 0", out_avg, out_sum);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_truncate();
    start_run(1'b0);
    tests_run++;
    if (in_ready !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL trunc_in_ready: got in_ready %b busy %b expected 1 1", in_ready, busy);
    end
    feed(8'd10); feed(8'd20); feed(8'd30); feed(8'd42);
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL trunc_calc: got out_valid %b in_ready %b busy %b expected 0 0 1",
               out_valid, in_ready, busy);
    end
    tick();
    tests_run++;
    if (out_valid !== 1'b1 || out_sum !== 10'd102 || out_avg !== 8'd25) begin
      failures++;
      $display("FAIL trunc_result: got valid %b sum %0d avg %0d expected 1 102 25",
               out_valid, out_sum, out_avg);
    end
    tick();
    tests_run++;
    if (out_valid !== 1'b0 || ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL trunc_after: got valid %b ready %b busy %b expected 0 1 0",
               out_valid, ready, busy);
    end
  endtask

  task automatic test_round();
    start_run(1'b1);
    round = 1'b0;  // only the value latched in ARM should matter
    feed(8'd10); feed(8'd20); feed(8'd30); feed(8'd42);
    tick();
    tests_run++;
    if (out_valid !== 1'b1 || out_sum !== 10'd102 || out_avg !== 8'd26) begin
      failures++;
      $display("FAIL round_result: got valid %b sum %0d avg %0d expected 1 102 26",
               out_valid, out_sum, out_avg);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    start_run(1'b0);
    feed(8'd1); feed(8'd1); feed(8'd1); feed(8'd1);
    tick();
    tests_run++;
    if (out_valid !== 1'b1 || out_sum !== 10'd4 || out_avg !== 8'd1) begin
      failures++;
      $display("FAIL b2b_first: got valid %b sum %0d avg %0d expected 1 4 1",
               out_valid, out_sum, out_avg);
    end
    start = 1'b1;
    round = 1'b1;
    tick();
    tests_run++;
    if (ready !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL b2b_arm: got ready %b busy %b in_ready %b expected 0 1 0",
               ready, busy, in_ready);
    end
    start = 1'b0;
    tick();
    feed(8'd10); feed(8'd20); feed(8'd30); feed(8'd41);
    tick();
    tests_run++;
    if (out_valid !== 1'b1 || out_sum !== 10'd101 || out_avg !== 8'd25) begin
      failures++;
      $display("FAIL b2b_second: got valid %b sum %0d avg %0d expected 1 101 25",
               out_valid, out_sum, out_avg);
    end
    tick();
  endtask

  task automatic test_saturation_stall();
    start_run(1'b1);
    feed(8'd255); feed(8'd255);
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++;
      if (dut.acc !== 10'd510 || dut.cnt !== 2'd2 || in_ready !== 1'b1) begin
        failures++;
        $display("FAIL stall_hold[%0d]: got acc %0d cnt %0d in_ready %b expected 510 2 1",
                 i, dut.acc, dut.cnt, in_ready);
      end
    end
    feed(8'd255); feed(8'd255);
    tick();
    tests_run++;
    if (out_valid !== 1'b1 || out_sum !== 10'd1020 || out_avg !== 8'd255) begin
      failures++;
      $display("FAIL sat_result: got valid %b sum %0d avg %0d expected 1 1020 255",
               out_valid, out_sum, out_avg);
    end
    tick();
  endtask

  task automatic test_restart();
    start_run(1'b0);
    feed(8'd100); feed(8'd100);
    start    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'd100;
    tick();
    in_valid = 1'b0;
    tests_run++;
    if (busy !== 1'b1 || in_ready !== 1'b0 || dut.acc !== 10'd0 || dut.cnt !== 2'd0) begin
      failures++;
      $display("FAIL restart_arm: got busy %b in_ready %b acc %0d cnt %0d expected 1 0 0 0",
               busy, in_ready, dut.acc, dut.cnt);
    end
    tick();
    start = 1'b0;
    tick();
    feed(8'd1); feed(8'd2); feed(8'd3); feed(8'd4);
    tests_run++;
    if (out_avg !== 8'd255 || out_sum !== 10'd1020 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL restart_held: got avg %0d sum %0d valid %b expected 255 1020 0",
               out_avg, out_sum, out_valid);
    end
    tick();
    tests_run++;
    if (out_valid !== 1'b1 || out_sum !== 10'd10 || out_avg !== 8'd2) begin
      failures++;
      $display("FAIL restart_result: got valid %b sum %0d avg %0d expected 1 10 2",
               out_valid, out_sum, out_avg);
    end
    tick();
  endtask

  task automatic test_reset_mid_run();
    int pulses;
    pulses = 0;
    start_run(1'b0);
    feed(8'd50); feed(8'd60); feed(8'd70);
    in_valid = 1'b1;
    in_data  = 8'd80;
    #2;
    rst = 1'b1;
    #1;
    tests_run++;
    if (ready !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0 || dut.acc !== 10'd0) begin
      failures++;
      $display("FAIL rstrun_flags: got ready %b busy %b in_ready %b acc %0d expected 1 0 0 0",
               ready, busy, in_ready, dut.acc);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (out_valid) pulses++;
    end
    in_valid = 1'b0;
    tests_run++;
    if (pulses != 0 || out_avg !== 8'd0 || out_sum !== 10'd0 || ready !== 1'b1) begin
      failures++;
      $display("FAIL rstrun_after: got pulses %0d avg %0d sum %0d ready %b expected 0 0 0 1",
               pulses, out_avg, out_sum, ready);
    end
  endtask

  initial begin
    test_reset();
    test_truncate();
    test_round();
    test_back_to_back();
    test_saturation_stall();
    test_restart();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got no end expected end");
    $fatal(1, "timeout");
  end

endmodule
